apb_slave_regfile: RTL

APB completer (slave) holding a bank of 32-bit registers with programmable wait states and error response. Sits on the APB side of the AHB-to-APB bridge, driven by one bit of the bridge's `pselx` plus the shared `paddr`/`pwdata`/`pwrite`/`penable`. It returns `prdata`, `pready` and `pslverr`. It is the responder partner used to exercise and extend the bridge's read/write paths.

---
 rtl/apb_slave_regfile_if.sv | 29 ++
 rtl/apb_slave_regfile.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester (bridge side) and apb_slave_regfile.
//   psel    : select, one bit of the bridge's pselx
//   penable : access phase marker
//   pwrite  : 1 = write, 0 = read
//   paddr   : byte address, register index = paddr[31:2]
//   pwdata  : write data
//   prdata  : read data, valid with pready on a read
//   pready  : transfer completes this cycle
//   pslverr : error response, valid with pready
interface apb_slave_regfile_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of NREGS 32-bit word-addressed registers,
// WAIT_STATES programmable access-phase wait cycles and error decoding.
// Register 0 is read-only and returns ID_VALUE.
//
// Ports:
//   hclk    : clock, rising edge
//   hresetn : asynchronous active-low reset
//   apb     : APB slave modport (psel/penable/pwrite/paddr/pwdata in,
//             prdata/pready/pslverr out, all outputs registered)
//
// Build option: define APB_SLV_PSLVERR_EN to report decode errors on
// pslverr. Without it pslverr stays 0; errored writes are still dropped and
// errored reads still return 0, with identical timing.
module apb_slave_regfile #(
    parameter int unsigned NREGS       = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input logic             hclk,
    input logic             hresetn,
    apb_slave_regfile_if.slave apb
);

    localparam int unsigned IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] regs_q [NREGS];
    logic        wr_en;

    logic [31:0]     dec_addr;
    logic            dec_write;
    logic            dec_err;
    logic [IDXW-1:0] dec_idx;
    logic [31:0]     dec_rdata;

    // With zero wait states the response is registered on the same edge that
    // latches the setup phase, so decode from the bus while idle and from the
    // latched copy otherwise.
    always_comb begin
        dec_addr  = (state_q == S_IDLE) ? apb.paddr  : addr_q;
        dec_write = (state_q == S_IDLE) ? apb.pwrite : write_q;
        dec_idx   = dec_addr[2 +: IDXW];
        dec_err   = (dec_addr[1:0] != 2'b00)
                 || ({2'b00, dec_addr[31:2]} >= NREGS)
                 || (dec_write && (dec_addr[31:2] == 30'd0));
        dec_rdata = '0;
        if (!dec_err && !dec_write) begin
            dec_rdata = (dec_idx == '0) ? ID_VALUE : regs_q[dec_idx];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // penable without a preceding setup phase is ignored here
                if (apb.psel && !apb.penable) begin
                    addr_d  = apb.paddr;
                    wdata_d = apb.pwdata;
                    write_d = apb.pwrite;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d  = S_READY;
                        pready_d = 1'b1;
                        prdata_d = dec_rdata;
`ifdef APB_SLV_PSLVERR_EN
                        pslverr_d = dec_err;
`endif
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!apb.psel) begin
                    state_d = S_IDLE;
                end else if (apb.penable) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d    = '0;
                        state_d  = S_READY;
                        pready_d = 1'b1;
                        prdata_d = dec_rdata;
`ifdef APB_SLV_PSLVERR_EN
                        pslverr_d = dec_err;
`endif
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_READY: begin
                state_d = S_IDLE;
                wr_en   = apb.psel && write_q && !dec_err;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[dec_idx] <= wdata_q;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;

endmodule
